// File: rtl/io_bus_arb_pkg.sv
// Shared widths, owner tag encoding and read-tag type for the IO register bus arbiter.
package io_bus_arb_pkg;

    localparam int ADR_W      = 14;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/io_bus_arb_rr_pick2.sv
// Two-input picker: round-robin on contention or fixed m0 priority, combinational grant.
// Last-grant flop moves only on a grant; resets to m1 so m0 wins the first contention.
module io_rr_pick2
    import io_bus_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req0,
    input  logic   req1,
    output logic   gnt0,
    output logic   gnt1,
    output owner_e win
);

    owner_e last_q, last_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b1 & 1'b0;
        if (req0 && req1) begin
            if (RR_EN && (last_q == OWNER_M0)) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        win    = gnt1 ? OWNER_M1 : OWNER_M0;
        last_d = (gnt0 || gnt1) ? win : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWNER_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/io_bus_arb.sv
// Two-master arbiter for the IO register bus: grant in T, registered bus command in T+1, read rvalid in T+2.
// Masters hold their command until gnt; one grant per cycle, no other backpressure.
module io_bus_arb
    import io_bus_arb_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADR_W-1:0]  m0_adr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADR_W-1:0]  m1_adr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              dma_io_we,
    output logic [ADR_W-1:0]  dma_io_wadr,
    output logic [DATA_W-1:0] dma_io_wdata,
    output logic [ADR_W-1:0]  dma_io_radr,
    output logic              dma_io_radr_en,
    input  logic [DATA_W-1:0] dma_io_rdata
);

    owner_e win;
    logic   gnt_any;
    logic   win_we;
    logic [ADR_W-1:0]  win_adr;
    logic [DATA_W-1:0] win_wdata;

    logic              we_q, we_d;
    logic              radr_en_q, radr_en_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    tag_t              tag1_q, tag1_d;
    tag_t              tag2_q, tag2_d;

    io_rr_pick2 #(.RR_EN(RR_EN)) u_pick (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (m0_req),
        .req1  (m1_req),
        .gnt0  (m0_gnt),
        .gnt1  (m1_gnt),
        .win   (win)
    );

    always_comb begin
        gnt_any   = m0_gnt | m1_gnt;
        win_we    = (win == OWNER_M1) ? m1_we    : m0_we;
        win_adr   = (win == OWNER_M1) ? m1_adr   : m0_adr;
        win_wdata = (win == OWNER_M1) ? m1_wdata : m0_wdata;

        we_d      = gnt_any & win_we;
        radr_en_d = gnt_any & ~win_we;
        adr_d     = gnt_any ? win_adr : adr_q;
        wdata_d   = (gnt_any && win_we) ? win_wdata : wdata_q;

        // Stage 1 travels with radr_en; stage 2 lines up with the slave's returned data.
        tag1_d.vld   = radr_en_d;
        tag1_d.owner = win;
        tag2_d       = tag1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            radr_en_q <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
        end else begin
            we_q      <= we_d;
            radr_en_q <= radr_en_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
        end
    end

    assign dma_io_we      = we_q;
    assign dma_io_radr_en = radr_en_q;
    assign dma_io_wadr    = adr_q;
    assign dma_io_radr    = adr_q;
    assign dma_io_wdata   = wdata_q;

    assign m0_rvalid = tag2_q.vld && (tag2_q.owner == OWNER_M0);
    assign m1_rvalid = tag2_q.vld && (tag2_q.owner == OWNER_M1);
    assign m0_rdata  = dma_io_rdata;
    assign m1_rdata  = dma_io_rdata;

endmodule

// File: tb/tb_io_bus_arb.sv
// Directed bench for io_bus_arb: round-robin instance "dut" and fixed-priority instance "dut_fp" share stimulus.
module tb_io_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [13:0] m0_adr, m1_adr;
    logic [31:0] m0_wdata, m1_wdata, dma_io_rdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, dma_io_wdata;
    logic        dma_io_we, dma_io_radr_en;
    logic [13:0] dma_io_wadr, dma_io_radr;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_wdata;
    logic        fp_we, fp_radr_en;
    logic [13:0] fp_wadr, fp_radr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_bus_arb #(.RR_EN(1'b1), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
        .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en), .dma_io_rdata(dma_io_rdata)
    );

    io_bus_arb #(.RR_EN(1'b0), .DATA_W(32)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .dma_io_we(fp_we), .dma_io_wadr(fp_wadr), .dma_io_wdata(fp_wdata),
        .dma_io_radr(fp_radr), .dma_io_radr_en(fp_radr_en), .dma_io_rdata(dma_io_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (dma_io_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", dma_io_we); end
        n_cmp++; if (dma_io_radr_en !== 1'b0) begin n_bad++; $display("FAIL rst_radr_en: got %b want 0", dma_io_radr_en); end
        n_cmp++; if (dma_io_wadr !== 14'h0) begin n_bad++; $display("FAIL rst_wadr: got %h want 0", dma_io_wadr); end
        n_cmp++; if (dma_io_radr !== 14'h0) begin n_bad++; $display("FAIL rst_radr: got %h want 0", dma_io_radr); end
        n_cmp++; if (dma_io_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", dma_io_wdata); end
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_m0();
        m0_req = 1'b1; m0_we = 1'b1; m0_adr = 14'h3F80; m0_wdata = 32'h5;
        #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL wr_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        tick();
        m0_req = 1'b0;
        n_cmp++; if (dma_io_we !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", dma_io_we); end
        n_cmp++; if (dma_io_radr_en !== 1'b0) begin n_bad++; $display("FAIL wr_radr_en: got %b want 0", dma_io_radr_en); end
        n_cmp++; if (dma_io_wadr !== 14'h3F80) begin n_bad++; $display("FAIL wr_wadr: got %h want 3f80", dma_io_wadr); end
        n_cmp++; if (dma_io_wdata !== 32'h5) begin n_bad++; $display("FAIL wr_wdata: got %h want 5", dma_io_wdata); end
        tick();
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL wr_no_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        n_cmp++; if (dma_io_we !== 1'b0) begin n_bad++; $display("FAIL wr_we_drop: got %b want 0", dma_io_we); end
        n_cmp++; if (dma_io_wadr !== 14'h3F80) begin n_bad++; $display("FAIL wr_wadr_hold: got %h want 3f80", dma_io_wadr); end
    endtask

    task automatic test_read_m1();
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 14'h3F85; m1_wdata = 32'hDEAD;
        #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_bad++; $display("FAIL rd_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        tick();
        m1_req = 1'b0;
        n_cmp++; if (dma_io_radr_en !== 1'b1) begin n_bad++; $display("FAIL rd_radr_en: got %b want 1", dma_io_radr_en); end
        n_cmp++; if (dma_io_we !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", dma_io_we); end
        n_cmp++; if (dma_io_radr !== 14'h3F85) begin n_bad++; $display("FAIL rd_radr: got %h want 3f85", dma_io_radr); end
        n_cmp++; if (dma_io_wdata !== 32'h5) begin n_bad++; $display("FAIL rd_wdata_hold: got %h want 5", dma_io_wdata); end
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_early: got %b want 0", m1_rvalid); end
        tick();
        dma_io_rdata = 32'hA;
        #1;
        n_cmp++; if (m1_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_m1_rvalid: got %b want 1", m1_rvalid); end
        n_cmp++; if (m1_rdata !== 32'hA) begin n_bad++; $display("FAIL rd_m1_rdata: got %h want a", m1_rdata); end
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_m0_rvalid: got %b want 0", m0_rvalid); end
        tick();
        n_cmp++; if (m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_once: got %b want 0", m1_rvalid); end
    endtask

    task automatic test_round_robin();
        logic exp_g0, exp_rv0, exp_rv1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m0_we = 1'b0; m1_we = 1'b0; m0_adr = 14'h0010; m1_adr = 14'h0020;
        for (int c = 0; c < 6; c++) begin
            m0_req = (c < 4); m1_req = (c < 4);
            dma_io_rdata = 32'h100 + c;
            #1;
            exp_g0  = (c % 2 == 0);
            exp_rv0 = (c >= 2) && ((c - 2) % 2 == 0);
            exp_rv1 = (c >= 2) && ((c - 2) % 2 == 1);
            if (c < 4) begin
                n_cmp++; if ({m0_gnt, m1_gnt} !== {exp_g0, ~exp_g0}) begin n_bad++; $display("FAIL rr_gnt c%0d: got %b want %b", c, {m0_gnt, m1_gnt}, {exp_g0, ~exp_g0}); end
            end
            n_cmp++; if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin n_bad++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1}); end
            tick();
        end
    endtask

    task automatic test_fixed_priority();
        m0_we = 1'b1; m1_we = 1'b1; m0_wdata = 32'h11; m1_wdata = 32'h22;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if ({fp_m0_gnt, fp_m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL fp_gnt c%0d: got %b want 10", c, {fp_m0_gnt, fp_m1_gnt}); end
            tick();
        end
        n_cmp++; if (fp_wdata !== 32'h11) begin n_bad++; $display("FAIL fp_wdata_m0: got %h want 11", fp_wdata); end
        m0_req = 1'b0;
        #1;
        n_cmp++; if ({fp_m0_gnt, fp_m1_gnt} !== 2'b01) begin n_bad++; $display("FAIL fp_gnt_m1: got %b want 01", {fp_m0_gnt, fp_m1_gnt}); end
        tick();
        m1_req = 1'b0;
        n_cmp++; if (fp_wdata !== 32'h22) begin n_bad++; $display("FAIL fp_wdata_m1: got %h want 22", fp_wdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        m0_req = 1'b1; m1_req = 1'b0; m0_we = 1'b0; m0_adr = 14'h0033;
        #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt: got %b want 1", m0_gnt); end
        tick();
        m0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({dma_io_we, dma_io_radr_en} !== 2'b00) begin n_bad++; $display("FAIL mid_strobes: got %b want 00", {dma_io_we, dma_io_radr_en}); end
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL mid_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_stale c%0d: got %b want 0", c, m0_rvalid); end
            tick();
        end
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0;
        #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL mid_first_rr: got %b want 10", {m0_gnt, m1_gnt}); end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 14'h3F84;
        #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_rd: got %b want 1", m0_gnt); end
        tick();
        m0_we = 1'b1; m0_adr = 14'h3F86; m0_wdata = 32'h77;
        #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_wr: got %b want 1", m0_gnt); end
        n_cmp++; if ({dma_io_radr_en, dma_io_we} !== 2'b10) begin n_bad++; $display("FAIL b2b_t1_strobes: got %b want 10", {dma_io_radr_en, dma_io_we}); end
        n_cmp++; if (dma_io_radr !== 14'h3F84) begin n_bad++; $display("FAIL b2b_radr: got %h want 3f84", dma_io_radr); end
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_rv_t1: got %b want 0", m0_rvalid); end
        tick();
        m0_req = 1'b0;
        dma_io_rdata = 32'h1234;
        #1;
        n_cmp++; if ({dma_io_radr_en, dma_io_we} !== 2'b01) begin n_bad++; $display("FAIL b2b_t2_strobes: got %b want 01", {dma_io_radr_en, dma_io_we}); end
        n_cmp++; if (dma_io_wadr !== 14'h3F86) begin n_bad++; $display("FAIL b2b_wadr: got %h want 3f86", dma_io_wadr); end
        n_cmp++; if (dma_io_wdata !== 32'h77) begin n_bad++; $display("FAIL b2b_wdata: got %h want 77", dma_io_wdata); end
        n_cmp++; if (m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rv_t2: got %b want 1", m0_rvalid); end
        n_cmp++; if (m0_rdata !== 32'h1234) begin n_bad++; $display("FAIL b2b_rdata: got %h want 1234", m0_rdata); end
        tick();
        n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_rv_t3: got %b want 0", m0_rvalid); end
        n_cmp++; if ({dma_io_radr_en, dma_io_we} !== 2'b00) begin n_bad++; $display("FAIL b2b_t3_strobes: got %b want 00", {dma_io_radr_en, dma_io_we}); end
        n_cmp++; if (dma_io_wdata !== 32'h77) begin n_bad++; $display("FAIL b2b_wdata_hold: got %h want 77", dma_io_wdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdata = '0;
        dma_io_rdata = '0;
        test_reset();
        test_write_m0();
        test_read_m1();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
